// File: rtl/elm_engine_scheduler_pkg.sv
// Shared definitions for the ELM engine scheduler: FSM encoding, default sizes
// and the digit reported when the engine never answers.
package elm_engine_scheduler_pkg;

  localparam int         NUM_BITS_DEF  = 256;
  localparam int         TIMEOUT_DEF   = 4096;
  localparam logic [3:0] TIMEOUT_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STREAM   = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_RESULT   = 2'd3
  } sched_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/elm_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, priority flips to the other
// requester whenever a grant is accepted.
module elm_rr_arbiter2
  import elm_engine_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  // prio_q = 1 means requester 1 wins a tie.
  logic prio_q;
  logic prio_d;

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = prio_q ? 2'b10 : 2'b01;
    end
  end

  assign prio_d = (accept_i && (grant_o != 2'b00)) ? grant_o[0] : prio_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/elm_engine_scheduler.sv
// Arbitrates two requesters onto one serial inference engine: captures a vector,
// streams it MSB-first on demand, then reports the engine digit or a timeout.
module elm_engine_scheduler
  import elm_engine_scheduler_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  input  logic                req1_valid,
  input  logic [NUM_BITS-1:0] req0_vec,
  input  logic [NUM_BITS-1:0] req1_vec,
  output logic                req0_ready,
  output logic                req1_ready,
  output logic                eng_start,
  output logic                eng_din,
  output logic                eng_din_valid,
  input  logic                eng_give_input,
  input  logic [3:0]          eng_hw_digit,
  input  logic                eng_output_valid,
  output logic                res_valid,
  output logic                res_id,
  output logic [3:0]          res_digit,
  output logic                res_timeout,
  output logic [15:0]         done_cnt
);

  localparam int BCW = $clog2(NUM_BITS) + 1;
  localparam int TCW = $clog2(TIMEOUT) + 1;
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(NUM_BITS - 1);
  localparam logic [TCW-1:0] LAST_TICK = TCW'(TIMEOUT - 1);

  sched_state_e        state_q;
  logic [NUM_BITS-1:0] shift_q;
  logic [BCW-1:0]      bit_cnt_q;
  logic [TCW-1:0]      tmo_cnt_q;
  logic                eng_start_q;
  logic                eng_din_q;
  logic                res_valid_q;
  logic                res_id_q;
  logic [3:0]          res_digit_q;
  logic                res_timeout_q;
  logic [15:0]         done_cnt_q;

  logic [1:0]          grant;
  logic                accept;

  // Gated by rst_n so no ready pulse can escape while reset is held.
  assign accept = (state_q == ST_IDLE) && rst_n && (req0_valid || req1_valid);

  elm_rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({req1_valid, req0_valid}),
    .accept_i (accept),
    .grant_o  (grant)
  );

  assign req0_ready    = accept && grant[0];
  assign req1_ready    = accept && grant[1];
  assign eng_din_valid = (state_q != ST_IDLE) || req0_valid || req1_valid;
  assign eng_start     = eng_start_q;
  assign eng_din       = eng_din_q;
  assign res_valid     = res_valid_q;
  assign res_id        = res_id_q;
  assign res_digit     = res_digit_q;
  assign res_timeout   = res_timeout_q;
  assign done_cnt      = done_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      eng_start_q   <= 1'b0;
      eng_din_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      res_id_q      <= 1'b0;
      res_digit_q   <= 4'h0;
      res_timeout_q <= 1'b0;
      done_cnt_q    <= 16'h0000;
    end else begin
      eng_start_q <= 1'b1;
      res_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shift_q   <= grant[1] ? req1_vec : req0_vec;
            res_id_q  <= grant[1];
            bit_cnt_q <= '0;
            state_q   <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (eng_give_input) begin
            eng_din_q <= shift_q[NUM_BITS-1];
            shift_q   <= shift_q << 1;
            bit_cnt_q <= bit_cnt_q + BCW'(1);
            if (bit_cnt_q == LAST_BIT) begin
              tmo_cnt_q <= '0;
              state_q   <= ST_WAIT_RES;
            end
          end
        end
        ST_WAIT_RES: begin
          if (eng_output_valid) begin
            res_digit_q   <= eng_hw_digit;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b1;
            done_cnt_q    <= sat_inc16(done_cnt_q);
            state_q       <= ST_RESULT;
          end else if (tmo_cnt_q == LAST_TICK) begin
            res_digit_q   <= TIMEOUT_DIGIT;
            res_timeout_q <= 1'b1;
            res_valid_q   <= 1'b1;
            done_cnt_q    <= sat_inc16(done_cnt_q);
            state_q       <= ST_RESULT;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TCW'(1);
          end
        end
        ST_RESULT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elm_engine_scheduler.sv
// Directed bench for elm_engine_scheduler: an engine model drives the serial
// handshake while a per-cycle monitor holds the arbitration/result model.
module tb_elm_engine_scheduler;

  localparam int NB = 256;
  localparam int TO = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [NB-1:0] req0_vec = '0, req1_vec = '0;
  logic          req0_ready, req1_ready;
  logic          eng_start, eng_din, eng_din_valid;
  logic          eng_give_input = 1'b0;
  logic [3:0]    eng_hw_digit = 4'h0;
  logic          eng_output_valid = 1'b0;
  logic          res_valid, res_id, res_timeout;
  logic [3:0]    res_digit;
  logic [15:0]   done_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  elm_engine_scheduler #(.NUM_BITS(NB), .TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req0_valid       (req0_valid),
    .req1_valid       (req1_valid),
    .req0_vec         (req0_vec),
    .req1_vec         (req1_vec),
    .req0_ready       (req0_ready),
    .req1_ready       (req1_ready),
    .eng_start        (eng_start),
    .eng_din          (eng_din),
    .eng_din_valid    (eng_din_valid),
    .eng_give_input   (eng_give_input),
    .eng_hw_digit     (eng_hw_digit),
    .eng_output_valid (eng_output_valid),
    .res_valid        (res_valid),
    .res_id           (res_id),
    .res_digit        (res_digit),
    .res_timeout      (res_timeout),
    .done_cnt         (done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Has a rising edge happened since reset released?
  logic post_rst = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) post_rst <= 1'b0;
    else        post_rst <= 1'b1;
  end

  // Per-cycle model: scheduler is either free or owns one accepted vector.
  bit        m_busy = 1'b0;
  bit        m_last = 1'b1;
  bit        m_id   = 1'b0;
  int        m_done = 0;
  logic [1:0] exp_ready;

  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      m_id   = 1'b0;
      m_done = 0;
    end
    exp_ready = 2'b00;
    if (rst_n && !m_busy) begin
      if (req0_valid && req1_valid) exp_ready = m_last ? 2'b01 : 2'b10;
      else                          exp_ready = {req1_valid, req0_valid};
    end
    chk("mon_ready", {req1_ready, req0_ready}, exp_ready);
    chk("mon_din_valid", eng_din_valid, m_busy || req0_valid || req1_valid);
    chk("mon_start", eng_start, post_rst);
    chk("mon_res_unexpected", res_valid && !m_busy, 1'b0);
    if (res_valid && m_busy) begin
      if (m_done < 65535) m_done++;
      chk("mon_res_id", res_id, m_id);
    end
    chk("mon_done_cnt", done_cnt, m_done);
    if (exp_ready != 2'b00) begin
      m_busy = 1'b1;
      m_id   = exp_ready[1];
      m_last = exp_ready[1];
    end else if (res_valid) begin
      m_busy = 1'b0;
    end
  end

  task automatic reset_checks(input string name);
    chk({name, "_rst_ready"}, {req1_ready, req0_ready}, 2'b00);
    chk({name, "_rst_start"}, eng_start, 1'b0);
    chk({name, "_rst_din"}, eng_din, 1'b0);
    chk({name, "_rst_res_valid"}, res_valid, 1'b0);
    chk({name, "_rst_res_id"}, res_id, 1'b0);
    chk({name, "_rst_res_digit"}, res_digit, 4'h0);
    chk({name, "_rst_res_timeout"}, res_timeout, 1'b0);
    chk({name, "_rst_done_cnt"}, done_cnt, 16'h0);
  endtask

  task automatic wait_grant(input logic exp_id, input int exp_wait, input string name);
    int w;
    bit seen;
    w = 0;
    seen = 1'b0;
    while (!seen && w < 64) begin
      #1;
      if (req0_ready || req1_ready) seen = 1'b1;
      else begin
        @(negedge clk);
        w++;
      end
    end
    chk({name, "_grant_seen"}, seen, 1'b1);
    chk({name, "_grant_id"}, req1_ready, exp_id);
    if (exp_wait >= 0) chk({name, "_grant_gap"}, w, exp_wait);
  endtask

  // Engine side: pulls nbits bits with an on/period give_input pattern.
  task automatic stream_bits(input logic [NB-1:0] vec, input int on, input int period,
                             input int nbits, input int spur_at, input string name);
    logic [NB-1:0] got;
    logic [NB-1:0] mask;
    int bits, cyc, early;
    got = '0;
    bits = 0;
    cyc = 0;
    early = 0;
    while (bits < nbits) begin
      eng_give_input   = ((cyc % period) < on);
      eng_output_valid = (spur_at >= 0) && (bits == spur_at) && !eng_give_input;
      eng_hw_digit     = 4'h3;
      @(negedge clk);
      if (eng_give_input) begin
        got[NB-1-bits] = eng_din;
        bits++;
      end
      if (res_valid) early++;
      cyc++;
    end
    eng_give_input   = 1'b0;
    eng_output_valid = 1'b0;
    mask = ~({NB{1'b1}} >> nbits);
    n_tests++;
    if (((got ^ vec) & mask) != '0) begin
      n_fail++;
      $display("[TB] FAIL %s_stream: got %h, expected %h", name, got & mask, vec & mask);
    end
    chk({name, "_early_result"}, early, 0);
  endtask

  task automatic finish_result(input int resp_delay, input logic [3:0] digit, input int exp_lat,
                               input logic exp_id, input logic [3:0] exp_digit, input logic exp_to,
                               input logic [15:0] exp_done, input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < TO + 16) begin
      eng_output_valid = (resp_delay >= 0) && (n == resp_delay);
      eng_hw_digit     = digit;
      @(negedge clk);
      n++;
      if (res_valid) seen = 1'b1;
    end
    eng_output_valid = 1'b0;
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_res_id"}, res_id, exp_id);
    chk({name, "_res_digit"}, res_digit, exp_digit);
    chk({name, "_res_timeout"}, res_timeout, exp_to);
    chk({name, "_done_cnt"}, done_cnt, exp_done);
  endtask

  logic [NB-1:0] vec_a, vec_b, vec_c, vec_d, vec_e, vec_f, vec_t;

  initial begin
    vec_a = {8{32'hC3A5_0F96}};
    vec_b = '1;
    vec_c = {8{32'h8421_7BDE}};
    vec_d = {8{32'h5A5A_F00F}};
    vec_e = {8{32'h0F1E_2D3C}};
    vec_f = {8{32'h6B2D_91E4}};

    // Reset held with a request pending: nothing may leak out.
    req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    reset_checks("init");
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single req0, continuous pull, engine answers digit 0 three cycles late.
    req0_vec = vec_a;
    req0_valid = 1'b1;
    wait_grant(1'b0, 0, "t1");
    @(negedge clk);
    req0_valid = 1'b0;
    stream_bits(vec_a, 1, 1, NB, -1, "t1");
    finish_result(3, 4'h0, 4, 1'b0, 4'h0, 1'b0, 16'd1, "t1");

    // Silent engine: timeout result from req1.
    @(negedge clk);
    req1_vec = vec_e;
    req1_valid = 1'b1;
    wait_grant(1'b1, 0, "tmo");
    @(negedge clk);
    req1_valid = 1'b0;
    stream_bits(vec_e, 1, 1, NB, -1, "tmo");
    finish_result(-1, 4'h0, TO, 1'b1, 4'hF, 1'b1, 16'd2, "tmo");

    // Reset at bit 100 of a stream, both requesters waiting.
    @(negedge clk);
    req1_vec = vec_b;
    req1_valid = 1'b1;
    wait_grant(1'b1, 0, "rst");
    @(negedge clk);
    req1_valid = 1'b0;
    stream_bits(vec_b, 1, 1, 100, -1, "rst");
    req0_vec = vec_c;
    req1_vec = vec_d;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    reset_checks("mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Both held: grants 0,1,0,1 back-to-back, each stream from bit 0.
    for (int i = 0; i < 4; i++) begin
      wait_grant(1'(i % 2), (i == 0) ? 0 : 1, $sformatf("rr%0d", i));
      @(negedge clk);
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      stream_bits((i % 2 == 1) ? vec_d : vec_c, 1, 1, NB, -1, $sformatf("rr%0d", i));
      finish_result(0, 4'(i + 1), 1, 1'(i % 2), 4'(i + 1), 1'b0, 16'(i + 1), $sformatf("rr%0d", i));
    end

    // Engine noise while idle, gapped pulls, spurious output_valid mid-stream.
    @(negedge clk);
    eng_give_input = 1'b1;
    eng_output_valid = 1'b1;
    eng_hw_digit = 4'h9;
    repeat (2) @(negedge clk);
    req0_vec = vec_f;
    req0_valid = 1'b1;
    wait_grant(1'b0, 0, "gap");
    @(negedge clk);
    req0_valid = 1'b0;
    stream_bits(vec_f, 1, 4, NB, 40, "gap");
    finish_result(2, 4'h7, 3, 1'b0, 4'h7, 1'b0, 16'd5, "gap");

    // Ten vectors, digits 0..9, alternating requesters, after a fresh reset.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vec_t = {8{32'h1357_9BDF ^ (32'(i) * 32'h0101_0101)}};
      @(negedge clk);
      if (i % 2 == 1) begin
        req1_vec = vec_t;
        req1_valid = 1'b1;
      end else begin
        req0_vec = vec_t;
        req0_valid = 1'b1;
      end
      wait_grant(1'(i % 2), 0, $sformatf("d%0d", i));
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      stream_bits(vec_t, 1, 1, NB, -1, $sformatf("d%0d", i));
      finish_result(i, 4'(i), i + 1, 1'(i % 2), 4'(i), 1'b0, 16'(i + 1), $sformatf("d%0d", i));
    end
    repeat (3) @(negedge clk);
    #1;
    chk("final_din_valid", eng_din_valid, 1'b0);
    chk("final_done_cnt", done_cnt, 16'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
